// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and constants for the pe_array sequencer and its operand buffers.
// Holds the FSM state codes, the issue-stage step descriptor and the buffer address widths.
package pe_array_ctrl_pkg;

   localparam int STEPS_DEF    = 8;
   localparam int ROWS_MAX_DEF = 16;
   localparam int IN_ADDR_W    = 4;
   localparam int J_W          = 3;
   localparam int WT_ADDR_W    = IN_ADDR_W + J_W;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   typedef struct packed {
      logic           valid;
      logic [J_W-1:0] j;
      logic           last;
   } step_desc_t;

endpackage

// File: rtl/pe_step_counter.sv
// Nested row/step counter: j runs 0..STEPS-1 and carries into i.
// Counters advance only when hold is low; term flags the final (i, j) of the tile.
module pe_step_counter
   import pe_array_ctrl_pkg::*;
#(
   parameter int STEPS = STEPS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 hold,
   input  logic [IN_ADDR_W-1:0] i_last,
   output logic [IN_ADDR_W-1:0] i,
   output logic [J_W-1:0]       j,
   output logic                 last_row,
   output logic                 term
);

   localparam logic [J_W-1:0] J_LAST = J_W'(STEPS - 1);

   logic [IN_ADDR_W-1:0] i_q, i_d;
   logic [J_W-1:0]       j_q, j_d;

   always_comb begin
      i_d = i_q;
      j_d = j_q;
      if (clr) begin
         i_d = '0;
         j_d = '0;
      end else if (!hold) begin
         if (j_q == J_LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
         end else begin
            j_d = j_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_q <= '0;
         j_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

   assign i        = i_q;
   assign j        = j_q;
   assign last_row = (i_q == i_last);
   assign term     = last_row && (j_q == J_LAST);

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the 16-lane pe_array: issues operand reads, aligns add_number/keep/
// rounder_en with the returned data one cycle later, then waits for the rounder to finish.
module pe_array_ctrl
   import pe_array_ctrl_pkg::*;
#(
   parameter int STEPS     = STEPS_DEF,
   parameter int ROWS_MAX  = ROWS_MAX_DEF,
   parameter int DRAIN_TMO = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] tile_k,
   input  logic       abort,
   input  logic       stall,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       in_rd_en,
   output logic [3:0] in_rd_addr,
   output logic       wt_rd_en,
   output logic [6:0] wt_rd_addr,
   output logic [3:0] add_number,
   output logic       keep,
   output logic       rounder_en,
   input  logic       rounder_valid,
   input  logic [3:0] round_number
);

   localparam int                    TMO_W    = $clog2(DRAIN_TMO + 1);
   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(DRAIN_TMO - 1);
   localparam logic [3:0]            RN_LAST  = 4'(STEPS - 1);
   localparam logic [IN_ADDR_W-1:0]  K_FULL   = IN_ADDR_W'(ROWS_MAX - 1);

   state_t               state_q, state_d;
   logic [IN_ADDR_W-1:0] k_last_q, k_last_d;
   logic [TMO_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic                 err_flag_q, err_flag_d;
   step_desc_t           desc_q, desc_d;
   logic [3:0]           add_hold_q, add_hold_d;

   logic                 rd;
   logic                 cnt_clr;
   logic [IN_ADDR_W-1:0] cur_i;
   logic [J_W-1:0]       cur_j;
   logic                 last_row;
   logic                 term;

   // An abort cycle issues no read so no orphan data reaches the array.
   assign rd      = (state_q == ST_RUN) && !stall && !abort;
   assign cnt_clr = abort || ((state_q == ST_IDLE) && start);

   pe_step_counter #(.STEPS(STEPS)) u_step_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .hold     (!rd),
      .i_last   (k_last_q),
      .i        (cur_i),
      .j        (cur_j),
      .last_row (last_row),
      .term     (term)
   );

   always_comb begin
      state_d     = state_q;
      k_last_d    = k_last_q;
      drain_cnt_d = drain_cnt_q;
      err_flag_d  = err_flag_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               k_last_d   = (tile_k == 4'd0) ? K_FULL : tile_k - 4'd1;
               err_flag_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (rd && term) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            if (rounder_valid && (round_number == RN_LAST)) begin
               state_d = ST_DONE;
            end else if (drain_cnt_q == TMO_LAST) begin
               state_d    = ST_DONE;
               err_flag_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            drain_cnt_d = '0;
         end
      endcase
      if (abort) begin
         state_d     = ST_IDLE;
         drain_cnt_d = '0;
         err_flag_d  = 1'b0;
      end
   end

   // Issue stage: one descriptor per read, empty otherwise; add_number remembers the last step.
   always_comb begin
      desc_d = '0;
      if (rd) begin
         desc_d.valid = 1'b1;
         desc_d.j     = cur_j;
         desc_d.last  = last_row;
      end
      add_hold_d = desc_q.valid ? 4'(desc_q.j) : add_hold_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_last_q    <= '0;
         drain_cnt_q <= '0;
         err_flag_q  <= 1'b0;
         desc_q      <= '0;
         add_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_last_q    <= k_last_d;
         drain_cnt_q <= drain_cnt_d;
         err_flag_q  <= err_flag_d;
         desc_q      <= desc_d;
         add_hold_q  <= add_hold_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign err        = done && err_flag_q;
   assign in_rd_en   = rd;
   assign wt_rd_en   = rd;
   assign in_rd_addr = cur_i;
   assign wt_rd_addr = {cur_i, cur_j};
   assign add_number = desc_q.valid ? 4'(desc_q.j) : add_hold_q;
   assign keep       = !desc_q.valid;
   assign rounder_en = desc_q.valid && desc_q.last;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed-plus-random bench for pe_array_ctrl: a read-count model predicts every read
// address, the array-side alignment one cycle later, and the drain/timeout outcome.
module tb_pe_array_ctrl;

   localparam int STEPS     = 8;
   localparam int DRAIN_TMO = 64;

   logic       clk = 1'b0;
   logic       rst, start, abort, stall, rounder_valid;
   logic [3:0] tile_k, round_number;
   logic       busy, done, err, in_rd_en, wt_rd_en, keep, rounder_en;
   logic [3:0] in_rd_addr, add_number;
   logic [6:0] wt_rd_addr;

   int vectors     = 0;
   int miscompares = 0;
   int hold_j      = 0;

   always #5 clk = ~clk;

   pe_array_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .tile_k(tile_k), .abort(abort), .stall(stall),
      .busy(busy), .done(done), .err(err), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
      .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .add_number(add_number), .keep(keep),
      .rounder_en(rounder_en), .rounder_valid(rounder_valid), .round_number(round_number)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
      chk("rst_err", err, 0);           chk("rst_in_rd_en", in_rd_en, 0);
      chk("rst_wt_rd_en", wt_rd_en, 0); chk("rst_in_addr", in_rd_addr, 0);
      chk("rst_wt_addr", wt_rd_addr, 0); chk("rst_add", add_number, 0);
      chk("rst_keep", keep, 1);         chk("rst_rnd_en", rounder_en, 0);
   endtask

   // Array side shows the previous cycle's read, or holds the last step with keep=1.
   task automatic chk_array(input bit prev_rd, input int prev_j, input bit prev_last);
      chk("keep", keep, !prev_rd);
      chk("rounder_en", rounder_en, prev_rd && prev_last);
      chk("add_number", add_number, prev_rd ? prev_j : hold_j);
      if (prev_rd) hold_j = prev_j;
   endtask

   task automatic run_tile(input logic [3:0] tk, input int stall_pct, input int stall_from,
                           input int stall_len, input int rv_at, input int abort_at);
      int k, total, n, cyc, nstall, keep_seen, dlen, prev_j;
      bit prev_rd, prev_last, stl, exp_err;
      k = (tk == 4'd0) ? 16 : int'(tk);
      total = k * STEPS;
      n = 0; cyc = 0; nstall = 0; keep_seen = 0;
      prev_rd = 0; prev_j = 0; prev_last = 0;
      start = 1'b1; tile_k = tk;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      next_cycle();
      start = 1'b0; tile_k = 4'($urandom_range(15));
      while (n < total) begin
         cyc++;
         stl = (cyc >= stall_from && cyc < stall_from + stall_len) ||
               (int'($urandom_range(99)) < stall_pct);
         if (n == abort_at) stl = 1'b0;
         stall = stl;
         abort = (n == abort_at);
         start = (stall_pct > 0) && ($urandom_range(3) == 0);
         @(negedge clk);
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         chk_array(prev_rd, prev_j, prev_last);
         if (cyc >= 2 && keep === 1'b1) keep_seen++;
         if (n == abort_at) begin
            next_cycle();
            abort = 1'b0; start = 1'b0; stall = 1'b0;
            for (int c = 0; c < 2; c++) begin
               @(negedge clk);
               chk("abort_busy", busy, 0);
               chk("abort_done", done, 0);
               chk("abort_rd", in_rd_en, 0);
               chk_array(0, 0, 0);
               next_cycle();
            end
            $display("tile k=%0d aborted after %0d reads", k, n);
            return;
         end
         chk("in_rd_en", in_rd_en, !stl);
         chk("wt_rd_en", wt_rd_en, !stl);
         if (!stl) begin
            chk("in_rd_addr", in_rd_addr, n / STEPS);
            chk("wt_rd_addr", wt_rd_addr, n);
         end
         prev_rd = !stl; prev_j = n % STEPS; prev_last = (n / STEPS == k - 1);
         if (stl) nstall++; else n++;
         next_cycle();
      end
      chk("keep_cycles", keep_seen, nstall);
      exp_err = !(rv_at >= 0 && rv_at < DRAIN_TMO);
      dlen = exp_err ? DRAIN_TMO : rv_at + 1;
      for (int d = 0; d <= dlen; d++) begin
         if (d < dlen) begin
            rounder_valid = (d == rv_at) ? 1'b1 : 1'($urandom_range(1));
            round_number  = (d == rv_at) ? 4'd7 : 4'($urandom_range(6));
            start = 1'($urandom_range(1));
            stall = 1'($urandom_range(1));
         end else begin
            rounder_valid = 1'b0; start = 1'b0; stall = 1'b0;
         end
         @(negedge clk);
         chk("drain_busy", busy, 1);
         chk("drain_rd", in_rd_en, 0);
         chk("done", done, d == dlen);
         chk("err", err, (d == dlen) && exp_err);
         chk_array(prev_rd, prev_j, prev_last);
         prev_rd = 0;
         next_cycle();
      end
      rounder_valid = 1'b0; round_number = 4'd0;
      $display("tile k=%0d reads=%0d stalls=%0d drain=%0d err=%0d", k, total, nstall, dlen, exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; tile_k = 4'd0;
      rounder_valid = 1'b0; round_number = 4'd0;
      repeat (3) next_cycle();
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      next_cycle();

      run_tile(4'd1, 0, 0, 0, 3, -1);       // rounder at cycle 12, done at 13
      run_tile(4'd0, 0, 0, 0, $urandom_range(20), -1);
      run_tile(4'd2, 0, 5, 3, 2, -1);       // 3 stalls mid-row, last read at cycle 19
      for (int t = 0; t < 6; t++)
         run_tile(4'($urandom_range(15)), 30, 0, 0, $urandom_range(30), -1);
      run_tile(4'd1, 0, 0, 0, -1, -1);      // drain timeout
      run_tile(4'd2, 0, 0, 0, 0, 12);       // abort at i=1, j=4
      run_tile(4'd2, 0, 0, 0, 1, -1);

      start = 1'b1; abort = 1'b1; tile_k = 4'd5;
      next_cycle();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", busy, 0);
      chk("start_abort_rd", in_rd_en, 0);
      next_cycle();
      $display("start+abort in idle: stayed idle");

      start = 1'b1; tile_k = 4'd3;
      next_cycle();
      start = 1'b0;
      repeat (14) next_cycle();
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      hold_j = 0;
      next_cycle();
      $display("reset mid-run: outputs at reset values");
      run_tile(4'd3, 20, 0, 0, 5, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
